// File: rtl/nvdla_dmaif_pkg.sv
// Shared types and constants for the NVDLA read DMA interface arbiter.
package nvdla_dmaif_pkg;

    localparam int unsigned SIZE_LSB = 32;
    localparam int unsigned SIZE_W   = 15;
    // Wide enough for the largest supported channel count (8).
    localparam int unsigned CH_ID_W  = 3;

    localparam logic RAM_MC     = 1'b1;
    localparam logic RAM_CVSRAM = 1'b0;

    typedef struct packed {
        logic [CH_ID_W-1:0] ch_id;
        logic               ram_type;
        logic [SIZE_W-1:0]  size;
    } ord_entry_t;

    localparam int unsigned ORD_ENTRY_W = $bits(ord_entry_t);

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(val)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/nvdla_dmaif_ord_fifo.sv
// Flop-based synchronous FIFO tracking outstanding read requests in issue order.
module nvdla_dmaif_ord_fifo
    import nvdla_dmaif_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = ORD_ENTRY_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/nvdla_dmaif_rd_arb.sv
// Round-robin merge of client read requests onto one MCIF port with in-order response routing.
// Define NVDLA_DMAIF_CDT_EN to build the MC credit-latency pop counter.
module nvdla_dmaif_rd_arb
    import nvdla_dmaif_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned REQ_PD_W  = 47,
    parameter int unsigned RSP_PD_W  = 65,
    parameter int unsigned ORD_DEPTH = 16
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic [NUM_CH*REQ_PD_W-1:0]   ch_rd_req_pd,
    input  logic [NUM_CH-1:0]            ch_rd_req_vld,
    output logic [NUM_CH-1:0]            ch_rd_req_rdy,
    input  logic [NUM_CH-1:0]            ch_rd_req_ram_type,
    output logic [REQ_PD_W-1:0]          mcif_rd_req_pd,
    output logic                         mcif_rd_req_valid,
    input  logic                         mcif_rd_req_ready,
    input  logic [RSP_PD_W-1:0]          mcif_rd_rsp_pd,
    input  logic                         mcif_rd_rsp_valid,
    output logic                         mcif_rd_rsp_ready,
    output logic [RSP_PD_W-1:0]          ch_rd_rsp_pd,
    output logic [NUM_CH-1:0]            ch_rd_rsp_vld,
    input  logic [NUM_CH-1:0]            ch_rd_rsp_rdy,
    input  logic [NUM_CH-1:0]            ch_rd_cdt_lat_fifo_pop,
    output logic [clog2(NUM_CH+1)-1:0]   mcif_rd_cdt_lat_fifo_pop,
    output logic                         ord_fifo_empty
);

    localparam int unsigned CNT_W = clog2(NUM_CH + 1);

    logic [CH_ID_W-1:0]   r_last_grant;
    logic                 r_req_valid;
    logic [REQ_PD_W-1:0]  r_req_pd;
    logic [SIZE_W-1:0]    r_beat_cnt;

    logic                 w_any_vld;
    logic [CH_ID_W-1:0]   w_winner;
    logic [REQ_PD_W-1:0]  w_win_pd;
    logic                 w_win_ram;
    logic                 w_grant_en;
    logic                 w_ord_full;
    logic                 w_ord_empty;
    ord_entry_t           w_push_entry;
    logic [ORD_ENTRY_W-1:0] w_head_raw;
    ord_entry_t           w_head;
    logic                 w_head_rdy;
    logic                 w_rsp_hs;
    logic                 w_rsp_last;

    // Arbiter: first valid channel after last_grant, wrapping.
    always_comb begin
        w_any_vld = 1'b0;
        w_winner  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!w_any_vld && ch_rd_req_vld[i] && ((32'(r_last_grant) + k) % NUM_CH == i)) begin
                    w_any_vld = 1'b1;
                    w_winner  = CH_ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_win_pd  = '0;
        w_win_ram = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_winner == CH_ID_W'(i)) begin
                w_win_pd  = ch_rd_req_pd[i*REQ_PD_W +: REQ_PD_W];
                w_win_ram = ch_rd_req_ram_type[i];
            end
        end
    end

    assign w_grant_en = w_any_vld & ~w_ord_full & (~r_req_valid | mcif_rd_req_ready);

    always_comb begin
        ch_rd_req_rdy = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_rd_req_rdy[i] = w_grant_en & (w_winner == CH_ID_W'(i));
        end
    end

    assign w_push_entry.ch_id    = w_winner;
    assign w_push_entry.ram_type = w_win_ram;
    assign w_push_entry.size     = w_win_pd[SIZE_LSB +: SIZE_W];

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_req_valid  <= 1'b0;
            r_req_pd     <= '0;
            r_last_grant <= CH_ID_W'(NUM_CH - 1);
        end else if (w_grant_en) begin
            r_req_valid  <= 1'b1;
            r_req_pd     <= w_win_pd;
            r_last_grant <= w_winner;
        end else if (mcif_rd_req_ready) begin
            r_req_valid  <= 1'b0;
        end
    end

    assign mcif_rd_req_valid = r_req_valid;
    assign mcif_rd_req_pd    = r_req_pd;

    nvdla_dmaif_ord_fifo #(
        .DEPTH (ORD_DEPTH),
        .WIDTH (ORD_ENTRY_W)
    ) u_ord_fifo (
        .i_clk   (nvdla_core_clk),
        .i_rst   (nvdla_core_rst),
        .i_push  (w_grant_en),
        .i_wdata (w_push_entry),
        .i_pop   (w_rsp_last),
        .o_rdata (w_head_raw),
        .o_full  (w_ord_full),
        .o_empty (w_ord_empty)
    );

    assign w_head         = ord_entry_t'(w_head_raw);
    assign ord_fifo_empty = w_ord_empty;

    // Responses return in issue order, so the FIFO head owns the current beat.
    always_comb begin
        w_head_rdy    = 1'b0;
        ch_rd_rsp_vld = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_head.ch_id == CH_ID_W'(i)) begin
                w_head_rdy       = ch_rd_rsp_rdy[i];
                ch_rd_rsp_vld[i] = mcif_rd_rsp_valid & ~w_ord_empty;
            end
        end
    end

    assign mcif_rd_rsp_ready = ~w_ord_empty & w_head_rdy;
    assign ch_rd_rsp_pd      = mcif_rd_rsp_pd;
    assign w_rsp_hs          = mcif_rd_rsp_valid & mcif_rd_rsp_ready;
    assign w_rsp_last        = w_rsp_hs & (r_beat_cnt == w_head.size);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_beat_cnt <= '0;
        end else if (w_rsp_last) begin
            r_beat_cnt <= '0;
        end else if (w_rsp_hs) begin
            r_beat_cnt <= r_beat_cnt + SIZE_W'(1);
        end
    end

`ifdef NVDLA_DMAIF_CDT_EN
    logic [NUM_CH-1:0] r_mc_mask;
    logic [CNT_W-1:0]  r_cdt_pop;
    logic [NUM_CH-1:0] w_pop_bits;
    logic [CNT_W-1:0]  w_pop_cnt;

    assign w_pop_bits = ch_rd_cdt_lat_fifo_pop & r_mc_mask;

    always_comb begin
        w_pop_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_pop_cnt = w_pop_cnt + CNT_W'(w_pop_bits[i]);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_mc_mask <= {NUM_CH{RAM_MC}};
            r_cdt_pop <= '0;
        end else begin
            r_cdt_pop <= w_pop_cnt;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_grant_en && (w_winner == CH_ID_W'(i))) begin
                    r_mc_mask[i] <= w_win_ram;
                end
            end
        end
    end

    assign mcif_rd_cdt_lat_fifo_pop = r_cdt_pop;

    logic w_unused_bits;
    assign w_unused_bits = w_head.ram_type;
`else
    assign mcif_rd_cdt_lat_fifo_pop = '0;

    logic w_unused_bits;
    assign w_unused_bits = w_head.ram_type ^ (^ch_rd_cdt_lat_fifo_pop);
`endif

endmodule

// File: tb/tb_nvdla_dmaif_rd_arb.sv
// Directed self-checking bench for nvdla_dmaif_rd_arb (NUM_CH=4, ORD_DEPTH=16).
module tb_nvdla_dmaif_rd_arb;
    import nvdla_dmaif_pkg::*;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned REQ_PD_W  = 47;
    localparam int unsigned RSP_PD_W  = 65;
    localparam int unsigned ORD_DEPTH = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH*REQ_PD_W-1:0] ch_rd_req_pd;
    logic [NUM_CH-1:0]          ch_rd_req_vld;
    logic [NUM_CH-1:0]          ch_rd_req_rdy;
    logic [NUM_CH-1:0]          ch_rd_req_ram_type;
    logic [REQ_PD_W-1:0]        mcif_rd_req_pd;
    logic                       mcif_rd_req_valid;
    logic                       mcif_rd_req_ready;
    logic [RSP_PD_W-1:0]        mcif_rd_rsp_pd;
    logic                       mcif_rd_rsp_valid;
    logic                       mcif_rd_rsp_ready;
    logic [RSP_PD_W-1:0]        ch_rd_rsp_pd;
    logic [NUM_CH-1:0]          ch_rd_rsp_vld;
    logic [NUM_CH-1:0]          ch_rd_rsp_rdy;
    logic [NUM_CH-1:0]          ch_rd_cdt_lat_fifo_pop;
    logic [2:0]                 mcif_rd_cdt_lat_fifo_pop;
    logic                       ord_fifo_empty;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nvdla_dmaif_rd_arb #(
        .NUM_CH    (NUM_CH),
        .REQ_PD_W  (REQ_PD_W),
        .RSP_PD_W  (RSP_PD_W),
        .ORD_DEPTH (ORD_DEPTH)
    ) dut (
        .nvdla_core_clk           (clk),
        .nvdla_core_rst           (rst),
        .ch_rd_req_pd             (ch_rd_req_pd),
        .ch_rd_req_vld            (ch_rd_req_vld),
        .ch_rd_req_rdy            (ch_rd_req_rdy),
        .ch_rd_req_ram_type       (ch_rd_req_ram_type),
        .mcif_rd_req_pd           (mcif_rd_req_pd),
        .mcif_rd_req_valid        (mcif_rd_req_valid),
        .mcif_rd_req_ready        (mcif_rd_req_ready),
        .mcif_rd_rsp_pd           (mcif_rd_rsp_pd),
        .mcif_rd_rsp_valid        (mcif_rd_rsp_valid),
        .mcif_rd_rsp_ready        (mcif_rd_rsp_ready),
        .ch_rd_rsp_pd             (ch_rd_rsp_pd),
        .ch_rd_rsp_vld            (ch_rd_rsp_vld),
        .ch_rd_rsp_rdy            (ch_rd_rsp_rdy),
        .ch_rd_cdt_lat_fifo_pop   (ch_rd_cdt_lat_fifo_pop),
        .mcif_rd_cdt_lat_fifo_pop (mcif_rd_cdt_lat_fifo_pop),
        .ord_fifo_empty           (ord_fifo_empty)
    );

    function automatic logic [REQ_PD_W-1:0] mk_pd(input int unsigned size, input int unsigned addr);
        logic [REQ_PD_W-1:0] pd;
        pd        = '0;
        pd[31:0]  = addr;
        pd[46:32] = size[14:0];
        return pd;
    endfunction

    task automatic clear_inputs;
        ch_rd_req_pd           = '0;
        ch_rd_req_vld          = '0;
        ch_rd_req_ram_type     = '1;
        mcif_rd_req_ready      = 1'b0;
        mcif_rd_rsp_pd         = '0;
        mcif_rd_rsp_valid      = 1'b0;
        ch_rd_rsp_rdy          = '0;
        ch_rd_cdt_lat_fifo_pop = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        n_run++; if (mcif_rd_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b want 0", mcif_rd_req_valid); end
        n_run++; if (mcif_rd_req_pd !== '0) begin n_fail++; $display("FAIL reset_req_pd: got %h want 0", mcif_rd_req_pd); end
        n_run++; if (ch_rd_req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 0000", ch_rd_req_rdy); end
        n_run++; if (ch_rd_rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_vld: got %b want 0000", ch_rd_rsp_vld); end
        n_run++; if (mcif_rd_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %0b want 0", mcif_rd_rsp_ready); end
        n_run++; if (mcif_rd_cdt_lat_fifo_pop !== 3'd0) begin n_fail++; $display("FAIL reset_cdt_pop: got %0d want 0", mcif_rd_cdt_lat_fifo_pop); end
        n_run++; if (ord_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ord_empty: got %0b want 1", ord_fifo_empty); end
        @(negedge clk);
        rst = 1'b0;
        // Response with nothing outstanding must stall, not route.
        mcif_rd_rsp_valid = 1'b1;
        ch_rd_rsp_rdy     = 4'b1111;
        #1;
        n_run++; if (mcif_rd_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL empty_rsp_ready: got %0b want 0", mcif_rd_rsp_ready); end
        n_run++; if (ch_rd_rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL empty_rsp_vld: got %b want 0000", ch_rd_rsp_vld); end
        @(negedge clk);
        mcif_rd_rsp_valid = 1'b0;
    endtask

    task automatic test_single;
        logic [RSP_PD_W-1:0] beat;
        do_reset();
        @(negedge clk);
        ch_rd_req_vld        = 4'b0001;
        ch_rd_req_pd[0 +: 47] = mk_pd(3, 32'h1000);
        mcif_rd_req_ready    = 1'b1;
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_rdy: got %b want 0001", ch_rd_req_rdy); end
        n_run++; if (mcif_rd_req_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n: got %0b want 0", mcif_rd_req_valid); end
        @(negedge clk);
        ch_rd_req_vld = 4'b0000;
        #1;
        n_run++; if (mcif_rd_req_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_n1: got %0b want 1", mcif_rd_req_valid); end
        n_run++; if (mcif_rd_req_pd !== mk_pd(3, 32'h1000)) begin n_fail++; $display("FAIL single_pd: got %h want %h", mcif_rd_req_pd, mk_pd(3, 32'h1000)); end
        n_run++; if (ord_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL single_ord_busy: got %0b want 0", ord_fifo_empty); end
        @(negedge clk);
        #1;
        n_run++; if (mcif_rd_req_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b want 0", mcif_rd_req_valid); end
        for (int b = 0; b < 4; b++) begin
            beat              = RSP_PD_W'(64'hA5A5_0000_0000_0000 + 64'(b));
            mcif_rd_rsp_valid = 1'b1;
            mcif_rd_rsp_pd    = beat;
            ch_rd_rsp_rdy     = 4'b1111;
            #1;
            n_run++; if (ch_rd_rsp_vld !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_vld[%0d]: got %b want 0001", b, ch_rd_rsp_vld); end
            n_run++; if (mcif_rd_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL single_rsp_rdy[%0d]: got %0b want 1", b, mcif_rd_rsp_ready); end
            n_run++; if (ch_rd_rsp_pd !== beat) begin n_fail++; $display("FAIL single_rsp_pd[%0d]: got %h want %h", b, ch_rd_rsp_pd, beat); end
            n_run++; if (ord_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL single_ord_held[%0d]: got %0b want 0", b, ord_fifo_empty); end
            @(negedge clk);
        end
        mcif_rd_rsp_valid = 1'b0;
        #1;
        n_run++; if (ord_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_ord_done: got %0b want 1", ord_fifo_empty); end
    endtask

    task automatic test_round_robin;
        logic [NUM_CH-1:0] exp_oh;
        do_reset();
        @(negedge clk);
        ch_rd_req_pd[0   +: 47] = mk_pd(0, 32'h100);
        ch_rd_req_pd[47  +: 47] = mk_pd(0, 32'h200);
        ch_rd_req_pd[94  +: 47] = mk_pd(0, 32'h300);
        ch_rd_req_pd[141 +: 47] = mk_pd(0, 32'h400);
        ch_rd_req_vld     = 4'b1111;
        mcif_rd_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_oh = 4'b0001 << (k % 4);
            n_run++; if (ch_rd_req_rdy !== exp_oh) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, ch_rd_req_rdy, exp_oh); end
            if (k > 0) begin
                n_run++;
                if (mcif_rd_req_pd !== mk_pd(0, 32'h100 * (32'((k - 1) % 4) + 1))) begin
                    n_fail++;
                    $display("FAIL rr_pd[%0d]: got %h want %h", k, mcif_rd_req_pd, mk_pd(0, 32'h100 * (32'((k - 1) % 4) + 1)));
                end
            end
            @(negedge clk);
        end
        ch_rd_req_vld = 4'b0000;
        #1;
        n_run++; if (mcif_rd_req_pd !== mk_pd(0, 32'h400)) begin n_fail++; $display("FAIL rr_pd_last: got %h want %h", mcif_rd_req_pd, mk_pd(0, 32'h400)); end
        for (int k = 0; k < 8; k++) begin
            mcif_rd_rsp_valid = 1'b1;
            mcif_rd_rsp_pd    = RSP_PD_W'(k);
            ch_rd_rsp_rdy     = 4'b1111;
            #1;
            exp_oh = 4'b0001 << (k % 4);
            n_run++; if (ch_rd_rsp_vld !== exp_oh) begin n_fail++; $display("FAIL rr_rsp[%0d]: got %b want %b", k, ch_rd_rsp_vld, exp_oh); end
            @(negedge clk);
        end
        mcif_rd_rsp_valid = 1'b0;
        #1;
        n_run++; if (ord_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rr_ord_done: got %0b want 1", ord_fifo_empty); end
    endtask

    task automatic test_backpressure;
        do_reset();
        @(negedge clk);
        mcif_rd_req_ready      = 1'b0;
        ch_rd_req_vld          = 4'b0010;
        ch_rd_req_pd[47 +: 47] = mk_pd(0, 32'hA0);
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b0010) begin n_fail++; $display("FAIL bp_first: got %b want 0010", ch_rd_req_rdy); end
        @(negedge clk);
        ch_rd_req_vld          = 4'b0110;
        ch_rd_req_pd[47 +: 47] = mk_pd(0, 32'hB0);
        ch_rd_req_pd[94 +: 47] = mk_pd(0, 32'hC0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_run++; if (mcif_rd_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", c, mcif_rd_req_valid); end
            n_run++; if (mcif_rd_req_pd !== mk_pd(0, 32'hA0)) begin n_fail++; $display("FAIL bp_pd[%0d]: got %h want %h", c, mcif_rd_req_pd, mk_pd(0, 32'hA0)); end
            n_run++; if (ch_rd_req_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy[%0d]: got %b want 0000", c, ch_rd_req_rdy); end
            @(negedge clk);
        end
        mcif_rd_req_ready = 1'b1;
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b0100) begin n_fail++; $display("FAIL bp_release: got %b want 0100", ch_rd_req_rdy); end
        @(negedge clk);
        #1;
        n_run++; if (mcif_rd_req_pd !== mk_pd(0, 32'hC0)) begin n_fail++; $display("FAIL bp_next_pd: got %h want %h", mcif_rd_req_pd, mk_pd(0, 32'hC0)); end
        n_run++; if (ch_rd_req_rdy !== 4'b0010) begin n_fail++; $display("FAIL bp_b2b: got %b want 0010", ch_rd_req_rdy); end
        ch_rd_req_vld = 4'b0000;
    endtask

    task automatic test_fifo_full;
        do_reset();
        @(negedge clk);
        ch_rd_req_vld           = 4'b1000;
        ch_rd_req_pd[141 +: 47] = mk_pd(0, 32'h300);
        mcif_rd_req_ready       = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_run++; if (ch_rd_req_rdy !== 4'b1000) begin n_fail++; $display("FAIL full_fill[%0d]: got %b want 1000", k, ch_rd_req_rdy); end
            @(negedge clk);
        end
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b0000) begin n_fail++; $display("FAIL full_block: got %b want 0000", ch_rd_req_rdy); end
        @(negedge clk);
        mcif_rd_rsp_valid = 1'b1;
        mcif_rd_rsp_pd    = RSP_PD_W'(32'hF00D);
        ch_rd_rsp_rdy     = 4'b1111;
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b0000) begin n_fail++; $display("FAIL full_pop_same: got %b want 0000", ch_rd_req_rdy); end
        n_run++; if (mcif_rd_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL full_rsp_rdy: got %0b want 1", mcif_rd_rsp_ready); end
        n_run++; if (ch_rd_rsp_vld !== 4'b1000) begin n_fail++; $display("FAIL full_rsp_vld: got %b want 1000", ch_rd_rsp_vld); end
        @(negedge clk);
        mcif_rd_rsp_valid = 1'b0;
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b1000) begin n_fail++; $display("FAIL full_unblock: got %b want 1000", ch_rd_req_rdy); end
        @(negedge clk);
        ch_rd_req_vld = 4'b0000;
    endtask

    task automatic test_rsp_stall;
        do_reset();
        @(negedge clk);
        ch_rd_req_vld          = 4'b0100;
        ch_rd_req_pd[94 +: 47] = mk_pd(0, 32'h2000);
        mcif_rd_req_ready      = 1'b1;
        #1;
        n_run++; if (ch_rd_req_rdy !== 4'b0100) begin n_fail++; $display("FAIL stall_grant: got %b want 0100", ch_rd_req_rdy); end
        @(negedge clk);
        ch_rd_req_vld     = 4'b0000;
        mcif_rd_rsp_valid = 1'b1;
        mcif_rd_rsp_pd    = RSP_PD_W'(64'hDEAD_BEEF_1234);
        ch_rd_rsp_rdy     = 4'b1011;
        #1;
        n_run++; if (mcif_rd_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rdy: got %0b want 0", mcif_rd_rsp_ready); end
        n_run++; if (ch_rd_rsp_vld !== 4'b0100) begin n_fail++; $display("FAIL stall_vld: got %b want 0100", ch_rd_rsp_vld); end
        @(negedge clk);
        #1;
        n_run++; if (ord_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL stall_held: got %0b want 0", ord_fifo_empty); end
        ch_rd_rsp_rdy = 4'b1111;
        #1;
        n_run++; if (mcif_rd_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %0b want 1", mcif_rd_rsp_ready); end
        n_run++; if (ch_rd_rsp_pd !== RSP_PD_W'(64'hDEAD_BEEF_1234)) begin n_fail++; $display("FAIL stall_pd: got %h want %h", ch_rd_rsp_pd, RSP_PD_W'(64'hDEAD_BEEF_1234)); end
        @(negedge clk);
        mcif_rd_rsp_valid = 1'b0;
        #1;
        n_run++; if (ord_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %0b want 1", ord_fifo_empty); end
    endtask

    task automatic test_credit;
        logic [2:0] exp_three;
        logic [2:0] exp_all;
`ifdef NVDLA_DMAIF_CDT_EN
        exp_three = 3'd2;
        exp_all   = 3'd3;
`else
        exp_three = 3'd0;
        exp_all   = 3'd0;
`endif
        do_reset();
        @(negedge clk);
        ch_rd_req_ram_type = {RAM_MC, RAM_CVSRAM, RAM_MC, RAM_MC};
        ch_rd_req_vld      = 4'b0111;
        mcif_rd_req_ready  = 1'b1;
        repeat (3) @(negedge clk);
        ch_rd_req_vld          = 4'b0000;
        ch_rd_cdt_lat_fifo_pop = 4'b0111;
        #1;
        n_run++; if (mcif_rd_cdt_lat_fifo_pop !== 3'd0) begin n_fail++; $display("FAIL cdt_latency: got %0d want 0", mcif_rd_cdt_lat_fifo_pop); end
        @(negedge clk);
        ch_rd_cdt_lat_fifo_pop = 4'b0000;
        #1;
        n_run++; if (mcif_rd_cdt_lat_fifo_pop !== exp_three) begin n_fail++; $display("FAIL cdt_three: got %0d want %0d", mcif_rd_cdt_lat_fifo_pop, exp_three); end
        @(negedge clk);
        #1;
        n_run++; if (mcif_rd_cdt_lat_fifo_pop !== 3'd0) begin n_fail++; $display("FAIL cdt_idle: got %0d want 0", mcif_rd_cdt_lat_fifo_pop); end
        ch_rd_cdt_lat_fifo_pop = 4'b1111;
        @(negedge clk);
        ch_rd_cdt_lat_fifo_pop = 4'b0000;
        #1;
        n_run++; if (mcif_rd_cdt_lat_fifo_pop !== exp_all) begin n_fail++; $display("FAIL cdt_all: got %0d want %0d", mcif_rd_cdt_lat_fifo_pop, exp_all); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_rsp_stall();
        test_credit();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
